// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads to the
// instruction memory and hands {insn, pc} pairs to decode over valid/ready.
// An output register plus one skid entry absorb decode backpressure so no
// fetched word is lost or duplicated; redirects flush everything younger.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8002_0000
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction memory read port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_access_size,
  output logic              mem_rd_wr,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [31:0]       mem_data_out,
  // Redirect from branch/jump resolution
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  // Decode interface
  output logic [31:0]       insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              insn_valid,
  input  logic              insn_ready
);

  // Fetch PC and the address of the read currently in flight
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;

  // Output register seen by decode
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_insn_q, out_insn_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;

  // Skid entry, always younger than the output register
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_insn_q, skid_insn_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic              pop;
  logic              issue;
  logic [1:0]        occupancy;

  // Handshake and issue decision for the current cycle
  always_comb begin
    pop = out_valid_q && insn_ready;
    // Words already owned (held or in flight) once this cycle's pop leaves.
    // Never exceeds 2 because issue stops at capacity, so 2 bits suffice.
    occupancy = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop);
    issue = !mem_busy && !redirect && (occupancy < 2'd2);
  end

  // Next-state: PC advance, response routing, skid drain and redirect flush
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = issue;
    out_valid_d  = out_valid_q;
    out_insn_d   = out_insn_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_insn_d  = skid_insn_q;
    skid_pc_d    = skid_pc_q;

    if (issue) begin
      pc_d     = pc_q + ADDR_W'(4);
      req_pc_d = pc_q;
    end

    if (redirect) begin
      // Everything younger than a word decode may be popping right now is
      // discarded. A response arriving this cycle is simply not captured,
      // which is how the stale in-flight read gets dropped.
      pc_d         = redirect_pc & ~ADDR_W'(3);
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_insn_d   = skid_insn_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_insn_d  = mem_data_out;
        out_pc_d    = req_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_insn_d  = mem_data_out;
        out_pc_d    = req_pc_q;
      end else begin
        // Issue rule guarantees the skid is empty whenever this happens
        skid_valid_d = 1'b1;
        skid_insn_d  = mem_data_out;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      inflight_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_insn_q   <= 32'h0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_insn_q  <= 32'h0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      out_insn_q   <= out_insn_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_insn_q  <= skid_insn_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Memory and decode outputs
  always_comb begin
    mem_addr        = pc_q;
    mem_access_size = 2'b00;
    mem_rd_wr       = 1'b1;
    mem_enable      = issue && !reset;
    insn            = out_insn_q;
    insn_pc         = out_pc_q;
    insn_valid      = out_valid_q;
  end

`ifndef SYNTHESIS
  // Memory may not go busy directly after accepting a request
  busy_after_req_a: assert property (@(posedge clk) disable iff (reset)
    mem_enable |=> !mem_busy)
    else $error("fetch_unit: mem_busy asserted in the cycle after a request");

  // With the skid full no read can be outstanding, so pop+response+skid never meet
  no_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(pop && inflight_q && skid_valid_q))
    else $error("fetch_unit: pop, response and full skid in the same cycle");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit. A synthetic instruction memory returns a
// hash of the address one cycle after each request; a word-count model of the
// fetch stage predicts issue, valid and the exact {pc, insn} stream decode sees.
module tb_fetch_unit;

  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_access_size;
  logic          mem_rd_wr;
  logic          mem_enable;
  logic          mem_busy;
  logic [31:0]   mem_data_out = 32'h0;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   insn;
  logic [AW-1:0] insn_pc;
  logic          insn_valid;
  logic          insn_ready;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_access_size (mem_access_size),
    .mem_rd_wr       (mem_rd_wr),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data_out    (mem_data_out),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready)
  );

  always #5 clk = ~clk;

  // Program image stand-in: every address holds a distinct word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory: data valid the cycle after the request, junk otherwise
  always @(posedge clk) begin
    if (mem_enable) mem_data_out <= mem_word(mem_addr);
    else            mem_data_out <= $urandom;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: words owned by the stage, next pc decode must see,
  // next pc to fetch, and whether a read was issued last cycle.
  int          owned;
  logic [31:0] exp_next_pc;
  logic [31:0] fetch_pc;
  bit          last_en;
  bit          last_en_obs;

  task automatic model_reset();
    owned       = 0;
    exp_next_pc = BASE;
    fetch_pc    = BASE;
    last_en     = 1'b0;
    last_en_obs = 1'b0;
  endtask

  // One clock cycle: inputs already applied; check mid-cycle, then advance model
  task automatic cycle();
    bit v_exp, pop, en_exp;
    int occ;
    @(negedge clk);
    v_exp = (owned - (last_en ? 1 : 0)) > 0;
    pop   = v_exp && insn_ready;
    occ   = owned - (pop ? 1 : 0);
    en_exp = !mem_busy && !redirect && (occ < 2);
    check("insn_valid", 32'(insn_valid), 32'(v_exp));
    check("mem_enable", 32'(mem_enable), 32'(en_exp));
    if (en_exp) check("mem_addr", mem_addr, fetch_pc);
    if (v_exp) begin
      check("insn_pc", insn_pc, exp_next_pc);
      check("insn", insn, mem_word(exp_next_pc));
    end
    if (pop) exp_next_pc += 32'd4;
    if (redirect) begin
      owned       = 0;
      exp_next_pc = redirect_pc & ~32'd3;
      fetch_pc    = redirect_pc & ~32'd3;
    end else begin
      owned = occ + (en_exp ? 1 : 0);
      if (en_exp) fetch_pc += 32'd4;
    end
    last_en     = en_exp;
    last_en_obs = mem_enable;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(insn_valid), 32'd0);
    check({tag, "_insn"}, insn, 32'd0);
    check({tag, "_insn_pc"}, insn_pc, 32'd0);
    check({tag, "_en"}, 32'(mem_enable), 32'd0);
    check({tag, "_addr"}, mem_addr, BASE);
  endtask

  initial begin
    reset       = 1'b1;
    insn_ready  = 1'b0;
    mem_busy    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("access_size", 32'(mem_access_size), 32'd0);
    check("rd_wr", 32'(mem_rd_wr), 32'd1);

    // 1: stream from reset, one insn per cycle from cycle 2
    reset      = 1'b0;
    insn_ready = 1'b1;
    repeat (10) cycle();

    // 2: decode stalls 3 cycles, then resumes
    insn_ready = 1'b0;
    repeat (3) cycle();
    insn_ready = 1'b1;
    repeat (6) cycle();

    // 3: redirect with no pop while a read is in flight
    insn_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0043;
    cycle();
    redirect   = 1'b0;
    insn_ready = 1'b1;
    cycle();
    cycle();
    check("redir_n3_valid", 32'(insn_valid), 32'd1);
    check("redir_n3_pc", insn_pc, 32'h8002_0040);
    repeat (5) cycle();

    // 4: redirect in the same cycle as a pop
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0100;
    cycle();
    redirect = 1'b0;
    repeat (6) cycle();

    // 5: fill to capacity, then memory busy for 2 cycles
    insn_ready = 1'b0;
    cycle();
    mem_busy   = 1'b1;
    insn_ready = 1'b1;
    repeat (2) cycle();
    mem_busy = 1'b0;
    repeat (6) cycle();

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // 6: reset pulsed with the skid full
    insn_ready = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b0;
    model_reset();
    insn_ready = 1'b1;
    repeat (6) cycle();

    // Random traffic: backpressure, busy and redirects
    for (int i = 0; i < 800; i++) begin
      insn_ready  = ($urandom_range(0, 3) != 0);
      mem_busy    = !last_en_obs && ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = BASE + 32'($urandom_range(0, 1023));
      cycle();
    end
    redirect = 1'b0;
    mem_busy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
